// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage instruction fields in; stall/flush, per-stage control and forwarding selects out.
// The unit takes the slave side; the datapath (or a bench) takes the master side.
interface pipe_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int OPC_W  = 7
);
    logic              id_valid;
    logic [OPC_W-1:0]  id_opcode;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              ex_branch_taken;

    logic              stall;
    logic              flush;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_alu_src;
    logic              ex_branch;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic [REG_AW-1:0] mem_rd;
    logic              wb_reg_write;
    logic              wb_mem_to_reg;
    logic [REG_AW-1:0] wb_rd;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  stall, flush,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_rd,
        input  mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd,
        input  wb_reg_write, wb_mem_to_reg, wb_rd,
        input  fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output stall, flush,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_rd,
        output mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd,
        output wb_reg_write, wb_mem_to_reg, wb_rd,
        output fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control for the 5-stage core: ID decode, ID/EX..MEM/WB control registers,
// load-use / RAW hazard stall, taken-branch flush and EX operand forwarding selects.
module pipe_ctrl_unit #(
    parameter int REG_AW = 5,
    parameter int OPC_W  = 7,
    parameter bit FWD_EN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    pipe_ctrl_unit_if.slave bus
);
    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic rw;
        logic mr;
        logic mw;
        logic m2r;
        logic alu_src;
        logic br;
    } ctrl_t;

    localparam logic [OPC_W-1:0] OPC_LOAD   = OPC_W'(7'b0000011);
    localparam logic [OPC_W-1:0] OPC_STORE  = OPC_W'(7'b0100011);
    localparam logic [OPC_W-1:0] OPC_RTYPE  = OPC_W'(7'b0110011);
    localparam logic [OPC_W-1:0] OPC_IALU   = OPC_W'(7'b0010011);
    localparam logic [OPC_W-1:0] OPC_BRANCH = OPC_W'(7'b1100011);

    ctrl_t     id_ctrl;
    logic      uses_rs1;
    logic      uses_rs2;

    ctrl_t     ex_c;
    reg_addr_t ex_rd_q, ex_rs1_q, ex_rs2_q;
    logic      mem_rw, mem_mr, mem_mw, mem_m2r;
    reg_addr_t mem_rd_q;
    logic      wb_rw, wb_m2r;
    reg_addr_t wb_rd_q;

    logic      ex_hit, mem_hit, load_use, raw_hz, stall_w, flush_w;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        id_ctrl  = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        if (bus.id_valid) begin
            case (bus.id_opcode)
                OPC_LOAD:   begin id_ctrl = '{rw: 1'b1, mr: 1'b1, mw: 1'b0, m2r: 1'b1, alu_src: 1'b1, br: 1'b0}; uses_rs1 = 1'b1; end
                OPC_STORE:  begin id_ctrl = '{rw: 1'b0, mr: 1'b0, mw: 1'b1, m2r: 1'b0, alu_src: 1'b1, br: 1'b0}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_RTYPE:  begin id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, m2r: 1'b0, alu_src: 1'b0, br: 1'b0}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                OPC_IALU:   begin id_ctrl = '{rw: 1'b1, mr: 1'b0, mw: 1'b0, m2r: 1'b0, alu_src: 1'b1, br: 1'b0}; uses_rs1 = 1'b1; end
                OPC_BRANCH: begin id_ctrl = '{rw: 1'b0, mr: 1'b0, mw: 1'b0, m2r: 1'b0, alu_src: 1'b0, br: 1'b1}; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
                default: ;
            endcase
        end
        // Writes to x0 are architecturally discarded, so never let them look like producers.
        if (bus.id_rd == '0) id_ctrl.rw = 1'b0;
    end

    // A nonzero producer rd matching a source the ID instruction actually reads.
    assign ex_hit  = (ex_rd_q != '0) &&
                     ((uses_rs1 && ex_rd_q == bus.id_rs1) || (uses_rs2 && ex_rd_q == bus.id_rs2));
    assign mem_hit = (mem_rd_q != '0) &&
                     ((uses_rs1 && mem_rd_q == bus.id_rs1) || (uses_rs2 && mem_rd_q == bus.id_rs2));

    assign load_use = bus.id_valid && ex_c.mr && ex_hit;
    assign raw_hz   = !FWD_EN && bus.id_valid && ((ex_c.rw && ex_hit) || (mem_rw && mem_hit));
    assign flush_w  = ex_c.br && bus.ex_branch_taken;
    assign stall_w  = (load_use || raw_hz) && !flush_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_c     <= '0;
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else if (stall_w || flush_w || !uses_rs1) begin
            // NOTE: state registers use nonblocking assignment so every stage samples pre-edge values.
            ex_c     <= '0;
            ex_rd_q  <= '0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
        end else begin
            ex_c     <= id_ctrl;
            ex_rd_q  <= bus.id_rd;
            ex_rs1_q <= bus.id_rs1;
            ex_rs2_q <= bus.id_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rw   <= 1'b0;
            mem_mr   <= 1'b0;
            mem_mw   <= 1'b0;
            mem_m2r  <= 1'b0;
            mem_rd_q <= '0;
            wb_rw    <= 1'b0;
            wb_m2r   <= 1'b0;
            wb_rd_q  <= '0;
        end else begin
            mem_rw   <= ex_c.rw;
            mem_mr   <= ex_c.mr;
            mem_mw   <= ex_c.mw;
            mem_m2r  <= ex_c.m2r;
            mem_rd_q <= ex_rd_q;
            wb_rw    <= mem_rw;
            wb_m2r   <= mem_m2r;
            wb_rd_q  <= mem_rd_q;
        end
    end

    // MEM is checked first: it holds the youngest value for that register.
    function automatic logic [1:0] fwd_sel(input reg_addr_t rs,
                                           input logic m_rw, input reg_addr_t m_rd,
                                           input logic w_rw, input reg_addr_t w_rd);
        if (m_rw && m_rd != '0 && m_rd == rs) return 2'b10;
        if (w_rw && w_rd != '0 && w_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    assign bus.fwd_a = FWD_EN ? fwd_sel(ex_rs1_q, mem_rw, mem_rd_q, wb_rw, wb_rd_q) : 2'b00;
    assign bus.fwd_b = FWD_EN ? fwd_sel(ex_rs2_q, mem_rw, mem_rd_q, wb_rw, wb_rd_q) : 2'b00;

    assign bus.stall          = stall_w;
    assign bus.flush          = flush_w;
    assign bus.ex_reg_write   = ex_c.rw;
    assign bus.ex_mem_read    = ex_c.mr;
    assign bus.ex_mem_write   = ex_c.mw;
    assign bus.ex_alu_src     = ex_c.alu_src;
    assign bus.ex_branch      = ex_c.br;
    assign bus.ex_rd          = ex_rd_q;
    assign bus.mem_reg_write  = mem_rw;
    assign bus.mem_mem_read   = mem_mr;
    assign bus.mem_mem_write  = mem_mw;
    assign bus.mem_mem_to_reg = mem_m2r;
    assign bus.mem_rd         = mem_rd_q;
    assign bus.wb_reg_write   = wb_rw;
    assign bus.wb_mem_to_reg  = wb_m2r;
    assign bus.wb_rd          = wb_rd_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: one instance with forwarding, one stall-only, driven from
// hand-derived vector tables through an expected-output queue plus reset sequences.
module tb_pipe_ctrl_unit;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    // 32-bit snapshot of every DUT output; ex={rw,mr,mw,alu_src,br}, mem={rw,mr,mw,m2r}, wb={rw,m2r}.
    typedef struct packed {
        logic       stall;
        logic       flush;
        logic [4:0] ex_c;
        logic [4:0] ex_rd;
        logic [3:0] mem_c;
        logic [4:0] mem_rd;
        logic [1:0] wb_c;
        logic [4:0] wb_rd;
        logic [1:0] fa;
        logic [1:0] fb;
    } obs_t;

    typedef struct packed {
        logic       v;
        logic [6:0] op;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       bt;
        obs_t       exp;
    } vec_t;

    typedef struct {
        int   sel;
        int   idx;
        obs_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb_q[$];
    vec_t vec_a[16];
    vec_t vec_b[9];

    always #5 clk = ~clk;

    pipe_ctrl_unit_if if_f ();
    pipe_ctrl_unit_if if_n ();

    pipe_ctrl_unit #(.REG_AW(5), .OPC_W(7), .FWD_EN(1'b1)) dut_fwd (.clk(clk), .rst_n(rst_n), .bus(if_f));
    pipe_ctrl_unit #(.REG_AW(5), .OPC_W(7), .FWD_EN(1'b0)) dut_nofwd (.clk(clk), .rst_n(rst_n), .bus(if_n));

    obs_t obs_f, obs_n;
    assign obs_f = {if_f.stall, if_f.flush,
                    if_f.ex_reg_write, if_f.ex_mem_read, if_f.ex_mem_write, if_f.ex_alu_src, if_f.ex_branch, if_f.ex_rd,
                    if_f.mem_reg_write, if_f.mem_mem_read, if_f.mem_mem_write, if_f.mem_mem_to_reg, if_f.mem_rd,
                    if_f.wb_reg_write, if_f.wb_mem_to_reg, if_f.wb_rd, if_f.fwd_a, if_f.fwd_b};
    assign obs_n = {if_n.stall, if_n.flush,
                    if_n.ex_reg_write, if_n.ex_mem_read, if_n.ex_mem_write, if_n.ex_alu_src, if_n.ex_branch, if_n.ex_rd,
                    if_n.mem_reg_write, if_n.mem_mem_read, if_n.mem_mem_write, if_n.mem_mem_to_reg, if_n.mem_rd,
                    if_n.wb_reg_write, if_n.wb_mem_to_reg, if_n.wb_rd, if_n.fwd_a, if_n.fwd_b};

    function automatic obs_t eo(logic s, logic f, logic [4:0] exc, int exrd, logic [3:0] mc, int mrd,
                                logic [1:0] wc, int wrd, logic [1:0] fa, logic [1:0] fb);
        return '{stall: s, flush: f, ex_c: exc, ex_rd: 5'(exrd), mem_c: mc, mem_rd: 5'(mrd),
                 wb_c: wc, wb_rd: 5'(wrd), fa: fa, fb: fb};
    endfunction

    function automatic vec_t mk(logic v, logic [6:0] op, int rs1, int rs2, int rd, logic bt, obs_t e);
        return '{v: v, op: op, rs1: 5'(rs1), rs2: 5'(rs2), rd: 5'(rd), bt: bt, exp: e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [6:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic bt);
        if (sel == 0) begin
            if_f.id_valid = v; if_f.id_opcode = op; if_f.id_rs1 = rs1;
            if_f.id_rs2 = rs2; if_f.id_rd = rd; if_f.ex_branch_taken = bt;
        end else begin
            if_n.id_valid = v; if_n.id_opcode = op; if_n.id_rs1 = rs1;
            if_n.id_rs2 = rs2; if_n.id_rd = rd; if_n.ex_branch_taken = bt;
        end
    endtask

    // Drive one vector just after the edge, queue its expectation, compare on the falling edge.
    task automatic apply(input int sel, input int idx, input vec_t v);
        sb_t got;
        @(posedge clk);
        #1;
        drive(sel, v.v, v.op, v.rs1, v.rs2, v.rd, v.bt);
        sb_q.push_back('{sel: sel, idx: idx, exp: v.exp});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            got = sb_q.pop_front();
            check($sformatf("%s_vec%0d", got.sel == 0 ? "fwd" : "nofwd", got.idx),
                  got.sel == 0 ? obs_f : obs_n, got.exp);
        end
    endtask

    initial begin
        // Forwarding instance: load-use, MEM-over-WB priority, x0 load, taken branch, decode of other opcodes.
        vec_a[0]  = mk(1, OP_LD, 1, 0, 5, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_a[1]  = mk(1, OP_R,  5, 7, 6, 0, eo(1, 0, 5'b11010, 5, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_a[2]  = mk(1, OP_R,  5, 7, 6, 0, eo(0, 0, 5'b00000, 0, 4'b1101, 5, 2'b00, 0, 2'b00, 2'b00));
        vec_a[3]  = mk(1, OP_R,  1, 2, 3, 0, eo(0, 0, 5'b10000, 6, 4'b0000, 0, 2'b11, 5, 2'b01, 2'b00));
        vec_a[4]  = mk(1, OP_R,  3, 4, 3, 0, eo(0, 0, 5'b10000, 3, 4'b1000, 6, 2'b00, 0, 2'b00, 2'b00));
        vec_a[5]  = mk(1, OP_R,  3, 3, 8, 0, eo(0, 0, 5'b10000, 3, 4'b1000, 3, 2'b10, 6, 2'b10, 2'b00));
        vec_a[6]  = mk(1, OP_LD, 1, 0, 0, 0, eo(0, 0, 5'b10000, 8, 4'b1000, 3, 2'b10, 3, 2'b10, 2'b10));
        vec_a[7]  = mk(1, OP_R,  0, 0, 1, 0, eo(0, 0, 5'b01010, 0, 4'b1000, 8, 2'b10, 3, 2'b00, 2'b00));
        vec_a[8]  = mk(1, OP_BR, 1, 2, 0, 0, eo(0, 0, 5'b10000, 1, 4'b0101, 0, 2'b10, 8, 2'b00, 2'b00));
        vec_a[9]  = mk(1, OP_LD, 1, 0, 9, 1, eo(0, 1, 5'b00001, 0, 4'b1000, 1, 2'b01, 0, 2'b10, 2'b00));
        vec_a[10] = mk(0, OP_R,  0, 0, 0, 1, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b10, 1, 2'b00, 2'b00));
        vec_a[11] = mk(1, OP_ST, 2, 3, 4, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_a[12] = mk(1, OP_I,  2, 0, 7, 0, eo(0, 0, 5'b00110, 4, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_a[13] = mk(1, OP_XX, 7, 0, 5, 0, eo(0, 0, 5'b10010, 7, 4'b0010, 4, 2'b00, 0, 2'b00, 2'b00));
        vec_a[14] = mk(0, OP_R,  0, 0, 3, 0, eo(0, 0, 5'b00000, 0, 4'b1000, 7, 2'b00, 4, 2'b00, 2'b00));
        vec_a[15] = mk(0, OP_R,  0, 0, 0, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b10, 7, 2'b00, 2'b00));

        // Stall-only instance: two-cycle RAW stall, then taken branch beating a MEM-stage RAW hazard.
        vec_b[0] = mk(1, OP_R,  1, 1, 2, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_b[1] = mk(1, OP_R,  2, 2, 3, 0, eo(1, 0, 5'b10000, 2, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_b[2] = mk(1, OP_R,  2, 2, 3, 0, eo(1, 0, 5'b00000, 0, 4'b1000, 2, 2'b00, 0, 2'b00, 2'b00));
        vec_b[3] = mk(1, OP_R,  2, 2, 3, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b10, 2, 2'b00, 2'b00));
        vec_b[4] = mk(1, OP_R,  5, 5, 4, 0, eo(0, 0, 5'b10000, 3, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));
        vec_b[5] = mk(1, OP_BR, 6, 6, 0, 0, eo(0, 0, 5'b10000, 4, 4'b1000, 3, 2'b00, 0, 2'b00, 2'b00));
        vec_b[6] = mk(1, OP_R,  4, 1, 7, 1, eo(0, 1, 5'b00001, 0, 4'b1000, 4, 2'b10, 3, 2'b00, 2'b00));
        vec_b[7] = mk(0, OP_R,  0, 0, 0, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b10, 4, 2'b00, 2'b00));
        vec_b[8] = mk(0, OP_R,  0, 0, 0, 0, eo(0, 0, 5'b00000, 0, 4'b0000, 0, 2'b00, 0, 2'b00, 2'b00));

        rst_n = 1'b0;
        drive(0, 0, OP_R, 0, 0, 0, 0);
        drive(1, 0, OP_R, 0, 0, 0, 0);
        #3;
        check("reset_fwd", obs_f, 32'h0);
        check("reset_nofwd", obs_n, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) apply(0, i, vec_a[i]);
        for (int i = 0; i < 9; i++) apply(1, i, vec_b[i]);

        // Mid-stream reset: a load sits in EX with its dependent in ID, then rst_n drops between edges.
        @(posedge clk);
        #1;
        drive(0, 1, OP_LD, 1, 0, 5, 0);
        @(posedge clk);
        #1;
        drive(0, 1, OP_R, 5, 7, 6, 0);
        @(negedge clk);
        check("midrst_pre_stall", {31'b0, if_f.stall}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_async_fwd", obs_f, 32'h0);
        check("midrst_async_nofwd", obs_n, 32'h0);
        drive(0, 0, OP_R, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", i), obs_f, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
